msk_tx_shaper: RTL and testbench
================================

// Module: msk_tx_shaper
// PURPOSE
//  Transmit-side MSK pulse shaper; counterpart of the receive half-sine matched filter.
//  Takes a serial bit stream (valid/ready) and emits offset I/Q half-sine-shaped samples.
//  Even bits go to the I arm and odd bits to the Q arm; Q is offset by one bit period.
//  Output is signed int16-style (+32767 = +1.0) and feeds the DAC/upconverter path.
// PARAMETERS
//  SPS  20     samples per bit; each arm pulse spans 2*SPS samples
//  WO   16     output sample width (signed)
//  AMP  32767  pulse peak; LUT[n]=round(AMP*sin(pi*n/(2*SPS))), n=0..2*SPS-1; AMP<=2^(WO-1)-1
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   synchronous reset, active low
//  samp_en    in   1   sample-rate strobe; one output sample per clk with samp_en=1
//  bit_in     in   1   data bit: 1 -> +pulse, 0 -> -pulse
//  bit_valid  in   1   bit_in valid
//  bit_ready  out  1   block accepts bit_in; transfer = bit_valid & bit_ready at posedge
//  dout_i     out  WO  I-arm sample, signed
//  dout_q     out  WO  Q-arm sample, signed
//  dout_val   out  1   dout_i/dout_q valid this cycle
//  dout_last  out  1   final sample of a burst; only asserted with dout_val
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, counters 0, both arms empty.
//   dout_i=0, dout_q=0, dout_val=0, dout_last=0. Mid-burst reset aborts with no flush.
//  States:
//   IDLE   bit_ready=1. On transfer: I arm loaded with sign(bit_in), Q arm empty,
//          samp_cnt=0, start_arm=I -> RUN.
//   RUN    one sample per samp_en. bit_ready=1 only when samp_en & samp_cnt==SPS-1.
//          At that edge samp_cnt wraps to 0 and start_arm toggles.
//          The arm that just finished its 2*SPS pulse is reloaded with the accepted bit,
//          or marked empty if no transfer; no transfer -> FLUSH.
//   FLUSH  bit_ready=0; bit_valid ignored. Runs SPS more samples (other arm's second half).
//          Last sample has dout_last=1 -> IDLE.
//  Sample index: the arm started at the last boundary uses idx=samp_cnt;
//   the other arm uses idx=SPS+samp_cnt.
//   arm out = empty ? 0 : (sign ? +LUT[idx] : -LUT[idx]); negation never overflows.
//  Registered outputs: at a posedge with samp_en=1 and state in RUN/FLUSH, dout_i/q
//   are computed from pre-edge state, dout_val<=1, then counters advance.
//   Otherwise dout_val<=0, dout_last<=0, and dout_i/q<=0.
//  samp_en=0 freezes all state; bit_ready=0 in RUN/FLUSH.
//  Latency: with samp_en held 1, first dout_val=1 in the 2nd cycle after the accepting edge.
//  No combinational path from bit_valid to bit_ready. bit_in is sampled only on transfer.
//  Burst of N bits gives exactly (N+1)*SPS valid samples.
//  I pulse for bit 2m covers samples [2m*SPS,(2m+2)*SPS).
//  Q pulse for bit 2m+1 covers samples [(2m+1)*SPS,(2m+3)*SPS).
//  LUT built at elaboration (constant function), synthesizable ROM; no real types in logic.
// TESTING
//  T1 reset, samp_en=1, single bit 1 -> 40 valid samples.
//     dout_i=LUT[0..39] (0,2571,5126,..,32767@20,..,2571); dout_q=0; dout_last on sample 40.
//  T2 bits 1,0 back-to-back -> 60 samples. I=+LUT[0..39] then 0.
//     Q=0 for samples 0-19, then -LUT[0..39] for samples 20-59. dout_last on sample 60.
//  T3 1000 random bits continuous -> I^2+Q^2 within AMP^2 +/-2*AMP in steady state.
//     Arm signs match bits; golden-model compare; matched filter back-to-back recovers bits.
//  T4 T1 with samp_en toggling 1,0 -> identical sample sequence; dout_val only after
//     samp_en=1 cycles; bit_ready only pulses on samp_en cycles.
//  T5 5 bits, bit_valid low at a boundary, high again during FLUSH -> FLUSH taken.
//     No bits accepted during FLUSH. 6*SPS samples, dout_last, IDLE.
//     Then a new burst starts cleanly with Q=0 in its first bit period.
//  T6 rst_n=0 at sample 25 of T2 -> next cycle all outputs 0, bit_ready=1 (IDLE).
//     Subsequent burst bit-exact to T1.

Source files
------------

// File: rtl/msk_tx_shaper.sv
// MSK transmit pulse shaper: serial bits in, offset I/Q half-sine samples out.
// Even bits drive the I arm, odd bits the Q arm, Q delayed by one bit period.
module msk_tx_shaper #(
    parameter int SPS = 20,
    parameter int WO  = 16,
    parameter int AMP = 32767
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 samp_en,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic signed [WO-1:0] dout_i,
    output logic signed [WO-1:0] dout_q,
    output logic                 dout_val,
    output logic                 dout_last
);

    localparam int     CW     = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int     IW     = $clog2(2 * SPS);
    localparam longint PI_Q30 = 64'sd3373259426;

    // Fixed-point Taylor sine folded to [0, pi/2]; evaluated only at elaboration
    function automatic logic signed [WO-1:0] f_lut(input int n);
        longint x;
        longint x2;
        longint term;
        longint acc;
        int     m;
        m    = (n > SPS) ? (2 * SPS - n) : n;
        x    = (PI_Q30 * longint'(m)) / longint'(2 * SPS);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k < 8; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        acc = (acc * longint'(AMP) + (64'sd1 <<< 29)) >>> 30;
        return WO'(acc);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    logic signed [WO-1:0] w_lut [2*SPS];

    for (genvar g = 0; g < 2 * SPS; g++) begin : g_lut
        assign w_lut[g] = f_lut(g);
    end

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_start_i;
    logic            r_i_full;
    logic            r_i_pos;
    logic            r_q_full;
    logic            r_q_pos;

    logic            w_bnd;
    logic            w_xfer;
    logic            w_act;
    logic [IW-1:0]   w_idx_a;
    logic [IW-1:0]   w_idx_b;
    logic [IW-1:0]   w_idx_i;
    logic [IW-1:0]   w_idx_q;
    logic signed [WO-1:0] w_lut_i;
    logic signed [WO-1:0] w_lut_q;
    logic signed [WO-1:0] w_smp_i;
    logic signed [WO-1:0] w_smp_q;

    assign w_bnd     = (r_cnt == CW'(SPS - 1));
    assign bit_ready = (r_state == S_IDLE)
                     | ((r_state == S_RUN) & samp_en & w_bnd);
    assign w_xfer    = bit_valid & bit_ready;
    assign w_act     = samp_en & ((r_state == S_RUN) | (r_state == S_FLUSH));

    // The arm started at the last boundary plays its first half
    assign w_idx_a = IW'(r_cnt);
    assign w_idx_b = IW'(SPS) + IW'(r_cnt);
    assign w_idx_i = r_start_i ? w_idx_a : w_idx_b;
    assign w_idx_q = r_start_i ? w_idx_b : w_idx_a;
    assign w_lut_i = w_lut[w_idx_i];
    assign w_lut_q = w_lut[w_idx_q];
    assign w_smp_i = !r_i_full ? '0 : (r_i_pos ? w_lut_i : -w_lut_i);
    assign w_smp_q = !r_q_full ? '0 : (r_q_pos ? w_lut_q : -w_lut_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_start_i <= 1'b1;
            r_i_full  <= 1'b0;
            r_i_pos   <= 1'b0;
            r_q_full  <= 1'b0;
            r_q_pos   <= 1'b0;
            dout_i    <= '0;
            dout_q    <= '0;
            dout_val  <= 1'b0;
            dout_last <= 1'b0;
        end else begin
            dout_val  <= w_act;
            dout_last <= w_act & (r_state == S_FLUSH) & w_bnd;
            dout_i    <= w_act ? w_smp_i : '0;
            dout_q    <= w_act ? w_smp_q : '0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_i_full  <= 1'b1;
                        r_i_pos   <= bit_in;
                        r_q_full  <= 1'b0;
                        r_cnt     <= '0;
                        r_start_i <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (samp_en) begin
                        if (w_bnd) begin
                            r_cnt     <= '0;
                            r_start_i <= ~r_start_i;
                            if (r_start_i) begin
                                r_q_full <= w_xfer;
                                if (w_xfer) r_q_pos <= bit_in;
                            end else begin
                                r_i_full <= w_xfer;
                                if (w_xfer) r_i_pos <= bit_in;
                            end
                            if (!w_xfer) r_state <= S_FLUSH;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (samp_en) begin
                        if (w_bnd) begin
                            r_cnt    <= '0;
                            r_i_full <= 1'b0;
                            r_q_full <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msk_tx_shaper.sv
// Bench for msk_tx_shaper: bursts checked against a pulse-superposition model.
// Random bits, strobe gaps, flush entry and mid-burst reset.
module tb_msk_tx_shaper;

    localparam int SPS = 20;
    localparam int WO  = 16;
    localparam int AMP = 32767;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 samp_en = 1'b0;
    logic                 bit_in = 1'b0;
    logic                 bit_valid = 1'b0;
    logic                 bit_ready;
    logic signed [WO-1:0] dout_i;
    logic signed [WO-1:0] dout_q;
    logic                 dout_val;
    logic                 dout_last;

    msk_tx_shaper #(.SPS(SPS), .WO(WO), .AMP(AMP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .samp_en   (samp_en),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .dout_i    (dout_i),
        .dout_q    (dout_q),
        .dout_val  (dout_val),
        .dout_last (dout_last)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int lut [2*SPS];
    int bits[$];
    int got_i[$];
    int got_q[$];
    int n_last;
    int bad_ready;
    int bad_val;
    int flush_acc;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sum of every pulse of one arm overlapping sample k
    function automatic int ref_arm(input int k, input int par);
        int s;
        s = 0;
        for (int j = k / SPS - 1; j <= k / SPS; j++) begin
            if (j >= 0 && j < bits.size() && (j % 2) == par) begin
                if (k >= j * SPS && k < (j + 2) * SPS)
                    s += bits[j] ? lut[k - j * SPS] : -lut[k - j * SPS];
            end
        end
        return s;
    endfunction

    task automatic burst(input int n, input bit tog, input bit late,
                         input int abort_at);
        int  i;
        int  cyc;
        int  quiet;
        bit  prev_en;
        bit  done;
        i = 0; cyc = 0; quiet = 0; prev_en = 1'b0; done = 1'b0;
        got_i.delete(); got_q.delete();
        n_last = 0; bad_ready = 0; bad_val = 0; flush_acc = 0;
        while (!done && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            if (dout_val) begin
                got_i.push_back(int'(dout_i));
                got_q.push_back(int'(dout_q));
                if (!prev_en) bad_val++;
                if (dout_last) begin
                    n_last++;
                    done = 1'b1;
                end
            end else if (dout_last) begin
                bad_val++;
            end
            if (done) break;
            if (abort_at > 0 && got_i.size() == abort_at) begin
                rst_n = 1'b0; bit_valid = 1'b0; samp_en = 1'b1;
                @(posedge clk); #1;
                chk("rst_i", int'(dout_i), 0);
                chk("rst_q", int'(dout_q), 0);
                chk("rst_val", int'(dout_val), 0);
                chk("rst_last", int'(dout_last), 0);
                chk("rst_ready", int'(bit_ready), 1);
                rst_n = 1'b1;
                return;
            end
            samp_en = tog ? ~samp_en : 1'b1;
            prev_en = samp_en;
            if (i < n) begin
                bit_valid = 1'b1;
                bit_in = bits[i][0];
            end else if (late && quiet > SPS + 1) begin
                bit_valid = 1'b1;
                bit_in = 1'b1;
            end else begin
                bit_valid = 1'b0;
            end
            if (i >= n) quiet++;
            #1;
            if (tog && !samp_en && bit_ready && i > 0) bad_ready++;
            if (bit_valid && bit_ready) begin
                if (i >= n) flush_acc++;
                else i++;
            end
        end
        bit_valid = 1'b0;
        samp_en = 1'b1;
        if (!done) chk("timeout", 0, 1);
    endtask

    task automatic verify(input string tag, input int n);
        chk({tag, "_count"}, got_i.size(), (n + 1) * SPS);
        chk({tag, "_last"}, n_last, 1);
        chk({tag, "_valgap"}, bad_val, 0);
        for (int k = 0; k < got_i.size(); k++) begin
            chk($sformatf("%s_I[%0d]", tag, k), got_i[k], ref_arm(k, 0));
            chk($sformatf("%s_Q[%0d]", tag, k), got_q[k], ref_arm(k, 1));
        end
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin
        int  e;
        int  lim;
        int  derr;
        longint acc;
        for (int n = 0; n < 2 * SPS; n++)
            lut[n] = $rtoi(AMP * $sin(3.141592653589793 * n / (2.0 * SPS)) + 0.5);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_i", int'(dout_i), 0);
        chk("reset_q", int'(dout_q), 0);
        chk("reset_val", int'(dout_val), 0);
        chk("reset_last", int'(dout_last), 0);
        chk("reset_ready", int'(bit_ready), 1);
        rst_n = 1'b1;
        idle(2);

        bits = '{1};
        burst(1, 1'b0, 1'b0, 0);
        verify("T1", 1);
        if (got_i.size() == 2 * SPS) begin
            chk("T1_I1", got_i[1], 2571);
            chk("T1_I2", got_i[2], 5126);
            chk("T1_peak", got_i[SPS], 32767);
            chk("T1_I39", got_i[2*SPS-1], 2571);
        end else begin
            chk("T1_len", got_i.size(), 2 * SPS);
        end
        idle(2);

        bits = '{1, 0};
        burst(2, 1'b0, 1'b0, 0);
        verify("T2", 2);
        idle(2);

        bits = '{1};
        burst(1, 1'b1, 1'b0, 0);
        verify("T4", 1);
        chk("T4_ready_gap", bad_ready, 0);
        idle(2);

        bits.delete();
        for (int k = 0; k < 5; k++) bits.push_back(int'($urandom_range(0, 1)));
        burst(5, 1'b0, 1'b1, 0);
        verify("T5", 5);
        chk("T5_flush_acc", flush_acc, 0);
        idle(2);
        bits.delete();
        for (int k = 0; k < 3; k++) bits.push_back(int'($urandom_range(0, 1)));
        burst(3, 1'b0, 1'b0, 0);
        verify("T5b", 3);
        idle(2);

        bits = '{1, 0};
        burst(2, 1'b0, 1'b0, 25);
        idle(1);
        bits = '{1};
        burst(1, 1'b0, 1'b0, 0);
        verify("T6", 1);
        idle(2);

        bits.delete();
        for (int k = 0; k < 1000; k++) bits.push_back(int'($urandom_range(0, 1)));
        burst(1000, 1'b0, 1'b0, 0);
        verify("T3", 1000);
        e = 0;
        lim = 1001 * SPS;
        if (got_i.size() < lim) lim = got_i.size();
        for (int k = SPS; k < lim - SPS; k++) begin
            acc = longint'(got_i[k]) * got_i[k] + longint'(got_q[k]) * got_q[k];
            if (acc > longint'(AMP) * AMP + 2 * AMP ||
                acc < longint'(AMP) * AMP - 2 * AMP) e++;
        end
        chk("T3_envelope", e, 0);
        derr = 0;
        for (int j = 0; j < 1000; j++) begin
            acc = 0;
            for (int t = 0; t < 2 * SPS; t++) begin
                if (j * SPS + t < got_i.size())
                    acc += longint'((j % 2 == 0) ? got_i[j*SPS+t] : got_q[j*SPS+t]) * lut[t];
            end
            if ((acc > 0 ? 1 : 0) != bits[j]) derr++;
        end
        chk("T3_mf_decode", derr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
